// File: rtl/line_buffer_pkg.sv
// Shared defaults and helpers for the three-line sliding pixel window.
package line_buffer_pkg;

    localparam int COLORDEPTH_DEF  = 11;
    localparam int SCREENWIDTH_DEF = 1600;

    // Number of completed lines held in the line memories, saturating at two.
    function automatic logic [1:0] fill_inc(input logic [1:0] fill);
        return (fill == 2'd2) ? 2'd2 : fill + 2'd1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line memory. Read-first: dout shows the word stored before this cycle's write.
module line_ram
    import line_buffer_pkg::*;
#(
    parameter int DEPTH = SCREENWIDTH_DEF,
    parameter int WIDTH = COLORDEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Three-line sliding pixel window: emits current, one-back and two-back pixels of one column.
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int COLORDEPTH  = COLORDEPTH_DEF,
    parameter int SCREENWIDTH = SCREENWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  datavalid,
    input  logic [COLORDEPTH-1:0] data_i,
    output logic [COLORDEPTH-1:0] px_line_n2_o,
    output logic [COLORDEPTH-1:0] px_line_n1_o,
    output logic [COLORDEPTH-1:0] px_line_n0_o
);

    localparam int AW = $clog2(SCREENWIDTH);

    logic [AW-1:0]         col_reg;
    logic [1:0]            fill_reg;
    logic [COLORDEPTH-1:0] n0_reg, n1_reg, n2_reg;
    logic [COLORDEPTH-1:0] r1, r2;
    logic                  wr_en;
    logic                  wrap;

    assign wr_en = datavalid && !rst;
    // Explicit compare so non-power-of-two widths wrap correctly.
    assign wrap  = (col_reg == AW'(SCREENWIDTH - 1));

    // LM2 takes LM1's old word, so it always lags LM1 by exactly one line.
    line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH)) lm1 (
        .clk  (clk),
        .addr (col_reg),
        .we   (wr_en),
        .din  (data_i),
        .dout (r1)
    );

    line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH)) lm2 (
        .clk  (clk),
        .addr (col_reg),
        .we   (wr_en),
        .din  (r1),
        .dout (r2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg  <= '0;
            fill_reg <= 2'd0;
            n0_reg   <= '0;
            n1_reg   <= '0;
            n2_reg   <= '0;
        end else if (datavalid) begin
            col_reg <= wrap ? '0 : col_reg + AW'(1);
            if (wrap) begin
                fill_reg <= fill_inc(fill_reg);
            end
            n0_reg <= data_i;
            // Masking hides stale memory words until the lines have been rewritten.
            n1_reg <= (fill_reg >= 2'd1) ? r1 : '0;
            n2_reg <= (fill_reg >= 2'd2) ? r2 : '0;
        end
    end

    assign px_line_n0_o = n0_reg;
    assign px_line_n1_o = n1_reg;
    assign px_line_n2_o = n2_reg;

endmodule

// File: tb/tb_line_buffer.sv
// Directed and randomized check of line_buffer against a per-line pixel history model.
module tb_line_buffer;

    localparam int CD = 11;
    localparam int W  = 1600;
    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          datavalid;
    logic [CD-1:0] data_i;
    logic [CD-1:0] px_line_n2_o, px_line_n1_o, px_line_n0_o;

    line_buffer #(.COLORDEPTH(CD), .SCREENWIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .datavalid    (datavalid),
        .data_i       (data_i),
        .px_line_n2_o (px_line_n2_o),
        .px_line_n1_o (px_line_n1_o),
        .px_line_n0_o (px_line_n0_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: every pixel remembered by (line, column); lines counted since the last reset.
    int unsigned   hist [NL][W];
    int            col_m = 0;
    int            li = 0;
    int            lsr = 0;
    logic [CD-1:0] exp_n0 = '0, exp_n1 = '0, exp_n2 = '0;

    task automatic chk(input string tag, input logic [CD-1:0] obs, input logic [CD-1:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s col=%0d observed=%0d expected=%0d", tag, col_m, obs, expv);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_n0"}, px_line_n0_o, exp_n0);
        chk({tag, "_n1"}, px_line_n1_o, exp_n1);
        chk({tag, "_n2"}, px_line_n2_o, exp_n2);
    endtask

    task automatic push(input logic [CD-1:0] v);
        exp_n0 = v;
        exp_n1 = (lsr >= 1) ? CD'(hist[(li + NL - 1) % NL][col_m]) : '0;
        exp_n2 = (lsr >= 2) ? CD'(hist[(li + NL - 2) % NL][col_m]) : '0;
        hist[li][col_m] = v;
        datavalid = 1'b1;
        data_i    = v;
        @(posedge clk);
        #1;
        datavalid = 1'b0;
        data_i    = CD'($urandom);
        chk_all("pix");
        col_m++;
        if (col_m == W) begin
            col_m = 0;
            li    = (li + 1) % NL;
            lsr++;
        end
    endtask

    task automatic idle(input int n);
        datavalid = 1'b0;
        repeat (n) begin
            data_i = CD'($urandom);
            @(posedge clk);
            #1;
            chk_all("hold");
        end
    endtask

    task automatic do_reset(input int n);
        datavalid = 1'b0;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_n0 = '0;
        exp_n1 = '0;
        exp_n2 = '0;
        chk_all("reset");
        if (col_m != 0) li = (li + 1) % NL;
        col_m = 0;
        lsr   = 0;
        $display("reset for %0d cycles: outputs checked", n);
    endtask

    // kind: 0 col, 1 2047-col, 2 col+5, 3 random
    task automatic send_line(input int kind, input int gap_at, input int stop_at);
        for (int c = 0; c < W; c++) begin
            logic [CD-1:0] v;
            if (c == stop_at) break;
            if (c == gap_at) idle(3);
            case (kind)
                0:       v = CD'(c);
                1:       v = CD'(2047 - c);
                2:       v = CD'(c + 5);
                default: v = CD'($urandom);
            endcase
            push(v);
        end
        $display("line kind=%0d gap_at=%0d stop_at=%0d done, %0d/%0d so far", kind, gap_at, stop_at, passed, total);
    endtask

    initial begin
        rst       = 1'b1;
        datavalid = 1'b0;
        data_i    = '0;
        do_reset(10);

        send_line(0, -1, -1);
        send_line(1, -1, -1);
        send_line(2, -1, -1);
        send_line(0, -1, -1);

        idle(448);
        send_line(3, 500, -1);
        send_line(3, -1, 800);
        do_reset(1);

        send_line(3, -1, -1);
        send_line(3, $urandom_range(1, W - 2), -1);
        idle($urandom_range(1, 40));
        send_line(3, -1, -1);
        send_line(3, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
